// File: rtl/tv_seq_gen_pkg.sv
// Shared definitions for the test-vector sequencer: mode codes, FSM states,
// maximal-length LFSR tap table and per-mode set size.
package tv_seq_pkg;

   localparam logic [1:0] MODE_BIN  = 2'd0;
   localparam logic [1:0] MODE_GRAY = 2'd1;
   localparam logic [1:0] MODE_WALK = 2'd2;
   localparam logic [1:0] MODE_LFSR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Tap masks for a shift-left Fibonacci LFSR; bit WIDTH-1 is always a tap.
   function automatic logic [15:0] lfsr_taps(input int unsigned width);
      case (width)
         2:       return 16'h0003;
         3:       return 16'h0006;
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [16:0] n_vectors(input logic [1:0] mode, input int unsigned width);
      case (mode)
         MODE_WALK: return 17'(width);
         MODE_LFSR: return (17'd1 << width) - 17'd1;
         default:   return 17'd1 << width;
      endcase
   endfunction

endpackage

// File: rtl/tv_seq_gen_if.sv
// Control and vector bus between the sequencer (master) and the checker bench (slave).
interface tv_seq_gen_if #(
   parameter int WIDTH = 3
);
   logic             start;
   logic             stop;
   logic [1:0]       mode;
   logic [WIDTH-1:0] vec;
   logic [WIDTH:0]   idx;
   logic             valid;
   logic             last;
   logic             busy;
   logic             done;

   modport master (
      input  start, stop, mode,
      output vec, idx, valid, last, busy, done
   );

   modport slave (
      output start, stop, mode,
      input  vec, idx, valid, last, busy, done
   );
endinterface

// File: rtl/tv_seq_gen_lfsr.sv
// Maximal-length Fibonacci LFSR that runs one step ahead of the displayed vector:
// q always holds the vector that follows the one currently presented.
module tv_lfsr
   import tv_seq_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             adv,
   output logic [WIDTH-1:0] q
);

   localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED     = WIDTH'(1);

   logic [WIDTH-1:0] lfsr_q, lfsr_d;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ^(v & TAPS)};
   endfunction

   // Loading places the successor of the seed, since the seed itself goes straight to the output.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load)
         lfsr_d = step(SEED);
      else if (adv)
         lfsr_d = step(lfsr_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lfsr_q <= '0;
      else
         lfsr_q <= lfsr_d;
   end

   assign q = lfsr_q;

endmodule

// File: rtl/tv_seq_gen.sv
// Test-vector sequencer: on start, presents a full binary, Gray, walking-one or
// LFSR pattern set, each vector held HOLD cycles, with registered handshake flags.
module tv_seq_gen
   import tv_seq_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int HOLD  = 1
) (
   input logic          clk,
   input logic          rst,
   tv_seq_gen_if.master bus
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

   state_e           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [7:0]       hold_q, hold_d;
   logic [WIDTH:0]   idx_q, idx_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             lfsr_load, lfsr_adv;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH:0]   idx_inc;
   logic [WIDTH:0]   n_last;

   tv_lfsr #(.WIDTH(WIDTH)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .adv  (lfsr_adv),
      .q    (lfsr_q)
   );

   function automatic logic [WIDTH-1:0] vec_of(input logic [1:0]       m,
                                               input logic [WIDTH:0]   i,
                                               input logic [WIDTH-1:0] lfsr_val);
      logic [WIDTH-1:0] b;
      b = i[WIDTH-1:0];
      case (m)
         MODE_GRAY: return b ^ (b >> 1);
         MODE_WALK: return WIDTH'(1) << i;
         MODE_LFSR: return lfsr_val;
         default:   return b;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      hold_d    = hold_q;
      idx_d     = idx_q;
      vec_d     = vec_q;
      valid_d   = valid_q;
      last_d    = last_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      idx_inc   = idx_q + (WIDTH+1)'(1);
      n_last    = (WIDTH+1)'(n_vectors(mode_q, WIDTH) - 17'd1);

      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d   = ST_RUN;
               mode_d    = bus.mode;
               hold_d    = 8'd0;
               idx_d     = '0;
               lfsr_load = 1'b1;
               vec_d     = vec_of(bus.mode, '0, WIDTH'(1));
               valid_d   = 1'b1;
               busy_d    = 1'b1;
               last_d    = 1'b0;
            end
         end
         ST_RUN: begin
            // Abort wins over a coincident vector wrap.
            if (bus.stop) begin
               state_d = ST_IDLE;
               hold_d  = 8'd0;
               idx_d   = '0;
               vec_d   = '0;
               valid_d = 1'b0;
               last_d  = 1'b0;
               busy_d  = 1'b0;
            end else if (hold_q == HOLD_LAST) begin
               hold_d = 8'd0;
               if (idx_q == n_last) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  idx_d   = '0;
                  vec_d   = '0;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  idx_d    = idx_inc;
                  lfsr_adv = 1'b1;
                  vec_d    = vec_of(mode_q, idx_inc, lfsr_q);
                  last_d   = (idx_inc == n_last);
               end
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_BIN;
         hold_q  <= 8'd0;
         idx_q   <= '0;
         vec_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.vec   = vec_q;
   assign bus.idx   = idx_q;
   assign bus.valid = valid_q;
   assign bus.last  = last_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_tv_seq_gen.sv
// Scoreboard bench for tv_seq_gen: a WIDTH=3/HOLD=1 instance and a WIDTH=4/HOLD=3 instance.
module tb_tv_seq_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tv_seq_gen_if #(.WIDTH(3)) a_if();
   tv_seq_gen_if #(.WIDTH(4)) b_if();

   tv_seq_gen #(.WIDTH(3), .HOLD(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
   tv_seq_gen #(.WIDTH(4), .HOLD(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

   typedef struct {
      logic [31:0] v;
      logic [31:0] i;
      logic        l;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   bit   sel      = 1'b0;
   int   lfsr3[7] = '{1, 2, 5, 3, 7, 6, 4};
   exp_t sb[$];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] o_vec();  return sel ? 32'(b_if.vec) : 32'(a_if.vec); endfunction
   function automatic logic [31:0] o_idx();  return sel ? 32'(b_if.idx) : 32'(a_if.idx); endfunction
   function automatic logic o_valid(); return sel ? b_if.valid : a_if.valid; endfunction
   function automatic logic o_last();  return sel ? b_if.last  : a_if.last;  endfunction
   function automatic logic o_busy();  return sel ? b_if.busy  : a_if.busy;  endfunction
   function automatic logic o_done();  return sel ? b_if.done  : a_if.done;  endfunction

   function automatic int n_exp(int w, logic [1:0] m);
      case (m)
         2'd2:    return w;
         2'd3:    return (1 << w) - 1;
         default: return 1 << w;
      endcase
   endfunction

   function automatic logic [31:0] exp_vec(logic [1:0] m, int i);
      case (m)
         2'd1:    return 32'(i ^ (i >> 1));
         2'd2:    return 32'(1 << i);
         2'd3:    return 32'(lfsr3[i]);
         default: return 32'(i);
      endcase
   endfunction

   task automatic drive(logic st, logic sp, logic [1:0] m);
      if (sel) begin
         b_if.start = st; b_if.stop = sp; b_if.mode = m;
      end else begin
         a_if.start = st; a_if.stop = sp; a_if.mode = m;
      end
   endtask

   task automatic check_idle(string tag);
      check({tag, "_flags"}, {28'd0, o_valid(), o_last(), o_busy(), o_done()}, 32'd0);
      check({tag, "_vec"}, o_vec(), 32'd0);
      check({tag, "_idx"}, o_idx(), 32'd0);
   endtask

   // One run: expected vectors are queued up front and popped on every valid cycle.
   task automatic run(logic [1:0] m, int stop_at, int rst_at, bit poke);
      int         w, h, n, busy_cnt;
      bit         ended, saw_done;
      logic [1:0] m_run;
      exp_t       e;
      w     = sel ? 4 : 3;
      h     = sel ? 3 : 1;
      n     = n_exp(w, m);
      m_run = poke ? ~m : m;
      sb.delete();
      for (int i = 0; i < n; i++)
         for (int k = 0; k < h; k++)
            sb.push_back('{v: exp_vec(m, i), i: 32'(i), l: (i == n - 1)});
      @(negedge clk);
      check_idle("pre_start");
      drive(1'b1, 1'b0, m);
      @(negedge clk);
      busy_cnt = 0;
      ended    = 1'b0;
      for (int cyc = 0; cyc < 100 && !ended; cyc++) begin
         drive(1'b0, 1'b0, m_run);
         if (o_done()) begin
            check("done_sb_empty", 32'(sb.size()), 32'd0);
            check("busy_cycles", 32'(busy_cnt), 32'(n * h));
            check("done_flags", {29'd0, o_valid(), o_busy(), o_last()}, 32'd0);
            check("done_vec", o_vec(), 32'd0);
            $display("run sel=%0d mode=%0d: done after %0d busy cycles", sel, m, busy_cnt);
            drive(1'b1, 1'b0, m);
            ended = 1'b1;
         end else if (!o_valid()) begin
            check("valid_gap", 32'(o_valid()), 32'd1);
            ended = 1'b1;
         end else if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
            ended = 1'b1;
         end else begin
            e = sb.pop_front();
            check("vec", o_vec(), e.v);
            check("idx", o_idx(), e.i);
            check("last", 32'(o_last()), 32'(e.l));
            check("busy", 32'(o_busy()), 32'd1);
            busy_cnt++;
            if (poke && cyc == 2)
               drive(1'b1, 1'b0, m_run);
            if (stop_at >= 0 && o_vec() == 32'(stop_at)) begin
               drive(1'b0, 1'b1, m);
               @(negedge clk);
               drive(1'b0, 1'b0, m);
               check("stop_valid", 32'(o_valid()), 32'd0);
               check("stop_vec", o_vec(), 32'd0);
               check("stop_busy", 32'(o_busy()), 32'd0);
               saw_done = 1'b0;
               repeat (12) begin
                  @(negedge clk);
                  saw_done |= o_done();
               end
               check("stop_no_done", 32'(saw_done), 32'd0);
               $display("run sel=%0d mode=%0d: stopped at vec=%0d", sel, m, stop_at);
               ended = 1'b1;
            end else if (rst_at >= 0 && o_vec() == 32'(rst_at)) begin
               rst = 1'b0;
               #1;
               check_idle("async_rst");
               @(negedge clk);
               check_idle("rst_held");
               rst = 1'b1;
               $display("run sel=%0d mode=%0d: reset at vec=%0d", sel, m, rst_at);
               ended = 1'b1;
            end
         end
         if (!ended)
            @(negedge clk);
      end
      if (!ended)
         check("run_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      a_if.start = 1'b0; a_if.stop = 1'b0; a_if.mode = 2'd0;
      b_if.start = 1'b0; b_if.stop = 1'b0; b_if.mode = 2'd0;
      @(negedge clk);
      sel = 1'b0; check_idle("reset_a");
      sel = 1'b1; check_idle("reset_b");
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      run(2'd0, -1, -1, 1'b0);
      run(2'd1, -1, -1, 1'b0);
      run(2'd3, -1, -1, 1'b0);
      run(2'd2, -1, -1, 1'b0);
      run(2'd0, -1, -1, 1'b1);
      run(2'd0, 5, -1, 1'b0);

      @(negedge clk);
      drive(1'b1, 1'b1, 2'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0);
      check_idle("start_stop_idle");
      @(negedge clk);
      check_idle("start_stop_idle2");
      $display("start+stop in IDLE: no run");

      run(2'd0, -1, 3, 1'b0);
      run(2'd0, -1, -1, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0);
      check_idle("a_after_done");

      sel = 1'b1;
      run(2'd0, -1, -1, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0);
      check_idle("b_final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
